// File: rtl/reservation_station.sv
// Single-clock reservation station: holds issued instructions until both operands are
// ready, snoops the CDB for wakeups and dispatches one entry at a time under a unit-busy counter.
module reservation_station #(
    parameter int DW   = 8,
    parameter int TW   = 3,
    parameter int NENT = 4
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          issue_v,
    input  logic [3:0]    issue_func,
    input  logic [3:0]    issue_rd,
    input  logic [TW-1:0] issue_rob,
    input  logic          issue_r1,
    input  logic          issue_r2,
    input  logic [DW-1:0] issue_v1,
    input  logic [DW-1:0] issue_v2,
    input  logic [TW-1:0] issue_t1,
    input  logic [TW-1:0] issue_t2,
    output logic          issue_ready,
    input  logic          cdb_v,
    input  logic [TW-1:0] cdb_tag,
    input  logic [DW-1:0] cdb_data,
    output logic [DW-1:0] rs1_data,
    output logic [DW-1:0] rs2_data,
    output logic [3:0]    func,
    output logic [3:0]    rd,
    output logic [TW-1:0] rob_ind,
    output logic          exec_b
);

    localparam int IW = (NENT > 1) ? $clog2(NENT) : 1;

    logic          busy  [NENT];
    logic [3:0]    func_q[NENT];
    logic [3:0]    rd_q  [NENT];
    logic [TW-1:0] rob_q [NENT];
    logic          r1_q  [NENT];
    logic          r2_q  [NENT];
    logic [DW-1:0] v1_q  [NENT];
    logic [DW-1:0] v2_q  [NENT];
    logic [TW-1:0] t1_q  [NENT];
    logic [TW-1:0] t2_q  [NENT];
    logic [2:0]    fu_cnt;

    logic          free_found;
    logic [IW-1:0] free_idx;
    logic          disp_found;
    logic [IW-1:0] disp_idx;
    logic          do_issue;
    logic          do_disp;
    logic          iss_r1;
    logic          iss_r2;
    logic [DW-1:0] iss_v1;
    logic [DW-1:0] iss_v2;

    // Remaining busy cycles of the functional unit after a dispatch of this opcode.
    function automatic logic [2:0] lat_of(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001: lat_of = 3'd1;
            4'b0010:          lat_of = 3'd3;
            4'b0011:          lat_of = 3'd5;
            default:          lat_of = 3'd0;
        endcase
    endfunction

    // Descending scans so the lowest matching index wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        disp_found = 1'b0;
        disp_idx   = '0;
        for (int i = NENT - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
            if (busy[i] && r1_q[i] && r2_q[i]) begin
                disp_found = 1'b1;
                disp_idx   = IW'(i);
            end
        end
    end

    // An operand whose producer broadcasts in the issue cycle is captured as ready.
    always_comb begin
        issue_ready = free_found;
        do_issue    = issue_v && free_found;
        do_disp     = disp_found && (fu_cnt == 3'd0);
        iss_r1      = issue_r1 || (cdb_v && (cdb_tag == issue_t1));
        iss_r2      = issue_r2 || (cdb_v && (cdb_tag == issue_t2));
        iss_v1      = issue_r1 ? issue_v1 : cdb_data;
        iss_v2      = issue_r2 ? issue_v2 : cdb_data;
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int i = 0; i < NENT; i++) begin
                busy[i] <= 1'b0;
            end
            fu_cnt   <= 3'd0;
            exec_b   <= 1'b0;
            rs1_data <= '0;
            rs2_data <= '0;
            func     <= 4'd0;
            rd       <= 4'd0;
            rob_ind  <= '0;
        end else begin
            exec_b <= do_disp;
            if (do_disp) begin
                rs1_data <= v1_q[disp_idx];
                rs2_data <= v2_q[disp_idx];
                func     <= func_q[disp_idx];
                rd       <= rd_q[disp_idx];
                rob_ind  <= rob_q[disp_idx];
                fu_cnt   <= lat_of(func_q[disp_idx]);
            end else if (fu_cnt != 3'd0) begin
                fu_cnt <= fu_cnt - 3'd1;
            end

            // The dispatched entry is fully ready, so its CDB snoop is a no-op.
            for (int i = 0; i < NENT; i++) begin
                if (do_disp && (disp_idx == IW'(i))) begin
                    busy[i] <= 1'b0;
                end
                if (do_issue && (free_idx == IW'(i))) begin
                    busy[i]   <= 1'b1;
                    func_q[i] <= issue_func;
                    rd_q[i]   <= issue_rd;
                    rob_q[i]  <= issue_rob;
                    r1_q[i]   <= iss_r1;
                    v1_q[i]   <= iss_v1;
                    t1_q[i]   <= issue_t1;
                    r2_q[i]   <= iss_r2;
                    v2_q[i]   <= iss_v2;
                    t2_q[i]   <= issue_t2;
                end else if (busy[i] && cdb_v) begin
                    if (!r1_q[i] && (t1_q[i] == cdb_tag)) begin
                        r1_q[i] <= 1'b1;
                        v1_q[i] <= cdb_data;
                    end
                    if (!r2_q[i] && (t2_q[i] == cdb_tag)) begin
                        r2_q[i] <= 1'b1;
                        v2_q[i] <= cdb_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Randomized plus directed bench for reservation_station: a behavioural model predicts each
// dispatch per clock edge and a monitor compares the DUT outputs against the queued predictions.
module tb_reservation_station;

    localparam int DW   = 8;
    localparam int TW   = 3;
    localparam int NENT = 4;

    logic          clk1 = 1'b0;
    logic          rst;
    logic          issue_v;
    logic [3:0]    issue_func;
    logic [3:0]    issue_rd;
    logic [TW-1:0] issue_rob;
    logic          issue_r1;
    logic          issue_r2;
    logic [DW-1:0] issue_v1;
    logic [DW-1:0] issue_v2;
    logic [TW-1:0] issue_t1;
    logic [TW-1:0] issue_t2;
    logic          issue_ready;
    logic          cdb_v;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic [3:0]    func;
    logic [3:0]    rd;
    logic [TW-1:0] rob_ind;
    logic          exec_b;

    reservation_station #(.DW(DW), .TW(TW), .NENT(NENT)) dut (
        .clk1(clk1), .rst(rst),
        .issue_v(issue_v), .issue_func(issue_func), .issue_rd(issue_rd), .issue_rob(issue_rob),
        .issue_r1(issue_r1), .issue_r2(issue_r2), .issue_v1(issue_v1), .issue_v2(issue_v2),
        .issue_t1(issue_t1), .issue_t2(issue_t2), .issue_ready(issue_ready),
        .cdb_v(cdb_v), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .func(func), .rd(rd),
        .rob_ind(rob_ind), .exec_b(exec_b)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        bit            busy;
        logic [3:0]    op;
        logic [3:0]    dst;
        logic [TW-1:0] rob;
        bit            r1;
        logic [DW-1:0] v1;
        logic [TW-1:0] t1;
        bit            r2;
        logic [DW-1:0] v2;
        logic [TW-1:0] t2;
    } ent_t;

    typedef struct {
        int            edge_no;
        bit            is_rst;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [3:0]    op;
        logic [3:0]    dst;
        logic [TW-1:0] rob;
    } rec_t;

    ent_t  m [NENT];
    rec_t  sb [$];
    rec_t  hold;
    int    next_ok = 0;
    int    edge_n = 0;
    bit    mon_en = 0;
    int    checks = 0;
    int    failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at edge %0d: actual=%0h expected=%0h", name, edge_n, act, exp);
        end
    endtask

    // Cycles until the unit may accept the next dispatch.
    function automatic int spacing(input logic [3:0] op);
        case (op)
            4'd0, 4'd1: return 2;
            4'd2:       return 4;
            4'd3:       return 6;
            default:    return 1;
        endcase
    endfunction

    // Drive one cycle of inputs and advance the model across the coming rising edge.
    task automatic applyStimulus(input bit iv, input logic [3:0] fn, input logic [3:0] dst,
                                 input logic [TW-1:0] rob, input bit r1, input logic [DW-1:0] v1,
                                 input logic [TW-1:0] t1, input bit r2, input logic [DW-1:0] v2,
                                 input logic [TW-1:0] t2, input bit cv, input logic [TW-1:0] ct,
                                 input logic [DW-1:0] cd, input bit rs);
        int   e;
        int   fi;
        int   di;
        rec_t r;
        @(negedge clk1);
        rst = rs; issue_v = iv; issue_func = fn; issue_rd = dst; issue_rob = rob;
        issue_r1 = r1; issue_v1 = v1; issue_t1 = t1;
        issue_r2 = r2; issue_v2 = v2; issue_t2 = t2;
        cdb_v = cv; cdb_tag = ct; cdb_data = cd;
        #1;
        e  = edge_n + 1;
        fi = -1;
        for (int i = NENT - 1; i >= 0; i--) if (!m[i].busy) fi = i;
        checkOutput("issue_ready", {31'd0, issue_ready}, {31'd0, fi >= 0});
        if (rs) begin
            for (int i = 0; i < NENT; i++) m[i].busy = 0;
            next_ok = 0;
            r = '{edge_no: e, is_rst: 1, d1: '0, d2: '0, op: '0, dst: '0, rob: '0};
            sb.push_back(r);
        end else begin
            di = -1;
            if (e >= next_ok)
                for (int i = NENT - 1; i >= 0; i--)
                    if (m[i].busy && m[i].r1 && m[i].r2) di = i;
            if (di >= 0) begin
                r = '{edge_no: e, is_rst: 0, d1: m[di].v1, d2: m[di].v2,
                      op: m[di].op, dst: m[di].dst, rob: m[di].rob};
                sb.push_back(r);
                m[di].busy = 0;
                next_ok = e + spacing(m[di].op);
            end
            if (cv)
                for (int i = 0; i < NENT; i++) if (m[i].busy) begin
                    if (!m[i].r1 && m[i].t1 == ct) begin m[i].r1 = 1; m[i].v1 = cd; end
                    if (!m[i].r2 && m[i].t2 == ct) begin m[i].r2 = 1; m[i].v2 = cd; end
                end
            if (iv && fi >= 0) begin
                m[fi] = '{busy: 1, op: fn, dst: dst, rob: rob,
                          r1: r1 || (cv && ct == t1), v1: r1 ? v1 : cd, t1: t1,
                          r2: r2 || (cv && ct == t2), v2: r2 ? v2 : cd, t2: t2};
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issueOp(input logic [3:0] fn, input logic [3:0] dst, input logic [TW-1:0] rob,
                           input bit r1, input logic [DW-1:0] v1, input logic [TW-1:0] t1,
                           input bit r2, input logic [DW-1:0] v2, input logic [TW-1:0] t2);
        applyStimulus(1, fn, dst, rob, r1, v1, t1, r2, v2, t2, 0, 0, 0, 0);
    endtask

    task automatic broadcast(input logic [TW-1:0] ct, input logic [DW-1:0] cd);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ct, cd, 0);
    endtask

    // Monitor: one sample per rising edge, compared against the queued prediction.
    always @(posedge clk1) begin
        bit exp_exec;
        #1;
        edge_n++;
        if (mon_en) begin
            exp_exec = 0;
            if (sb.size() > 0 && sb[0].edge_no == edge_n) begin
                hold = sb.pop_front();
                exp_exec = !hold.is_rst;
            end
            checkOutput("exec_b", {31'd0, exec_b}, {31'd0, exp_exec});
            checkOutput("rs1_data", 32'(rs1_data), 32'(hold.d1));
            checkOutput("rs2_data", 32'(rs2_data), 32'(hold.d2));
            checkOutput("func", 32'(func), 32'(hold.op));
            checkOutput("rd", 32'(rd), 32'(hold.dst));
            checkOutput("rob_ind", 32'(rob_ind), 32'(hold.rob));
        end
    end

    initial begin
        hold = '{edge_no: 0, is_rst: 1, d1: '0, d2: '0, op: '0, dst: '0, rob: '0};
        for (int i = 0; i < NENT; i++) m[i].busy = 0;
        rst = 1; issue_v = 0; issue_func = 0; issue_rd = 0; issue_rob = 0;
        issue_r1 = 0; issue_r2 = 0; issue_v1 = 0; issue_v2 = 0; issue_t1 = 0; issue_t2 = 0;
        cdb_v = 0; cdb_tag = 0; cdb_data = 0;
        repeat (2) @(posedge clk1);
        @(negedge clk1);
        mon_en = 1;

        // Ready add dispatches two edges after issue.
        issueOp(4'd0, 4'd4, 3'd2, 1, 8'd5, 0, 1, 8'd3, 0);
        idle(3);
        // Mul waits for tag 6, then dispatches with the broadcast value.
        issueOp(4'd2, 4'd1, 3'd5, 0, 8'd0, 3'd6, 1, 8'd7, 0);
        idle(3);
        broadcast(3'd6, 8'd9);
        idle(6);
        // Fill all entries, drop a fifth issue, then release them.
        for (int k = 0; k < NENT; k++) issueOp(4'd4, 4'(k), 3'(k), 0, 0, 3'd1, 1, 8'(k + 16), 0);
        issueOp(4'd0, 4'd9, 3'd7, 1, 8'hEE, 0, 1, 8'hEF, 0);
        idle(2);
        broadcast(3'd1, 8'h42);
        idle(8);
        // Div then add: spacing of six cycles.
        issueOp(4'd3, 4'd2, 3'd3, 1, 8'd100, 0, 1, 8'd7, 0);
        issueOp(4'd0, 4'd3, 3'd4, 1, 8'd1, 0, 1, 8'd2, 0);
        idle(10);
        // Operand captured from a coincident broadcast.
        applyStimulus(1, 4'd1, 4'd6, 3'd1, 1, 8'd11, 0, 0, 8'd0, 3'd3, 1, 3'd3, 8'hAA, 0);
        idle(3);
        // Reset with pending entries and a busy unit.
        issueOp(4'd3, 4'd5, 3'd0, 1, 8'd1, 0, 1, 8'd1, 0);
        for (int k = 0; k < 3; k++) issueOp(4'd0, 4'd7, 3'(k), 0, 0, 3'd7, 1, 8'd1, 0);
        idle(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);
        broadcast(3'd7, 8'h55);
        idle(6);

        for (int k = 0; k < 800; k++) begin
            applyStimulus($urandom_range(0, 1) == 1, 4'($urandom_range(0, 5)), 4'($urandom),
                          3'($urandom), $urandom_range(0, 2) == 0, 8'($urandom), 3'($urandom),
                          $urandom_range(0, 2) == 0, 8'($urandom), 3'($urandom),
                          $urandom_range(0, 1) == 1, 3'($urandom), 8'($urandom),
                          $urandom_range(0, 99) == 0);
        end
        idle(20);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
